disparo_sequencer: RTL and testbench

- Sits between the three-phase firing-pattern generator and the gate-driver pins of the MMC slave FPGA.
- Sequences converter start/stop and trips on fault.
- Latches the 12-bit leg command word only on switching-period boundaries.
- Expands each leg command bit into a complementary upper/lower gate pair with dead-time insertion, giving 24 gate outputs.

---
 rtl/disparo_pkg.sv | 25 ++
 rtl/leg_deadtime.sv | 67 ++++++
 rtl/disparo_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_disparo_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disparo_pkg.sv
// disparo_pkg: shared definitions for the disparo_sequencer slice.
//   - state_t      : encoded sequencer states (IDLE=0, ARM=1, RUN=2, STOP=3, TRIP=4)
//   - NLEGS        : number of converter legs (one command bit each)
//   - SAFE_CMD_DEF : leg command word applied outside RUN (1010 per phase)
//   - gate_idx()   : position of a leg's upper/lower gate inside the 24-bit gate bus
package disparo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_STOP = 3'd3,
    ST_TRIP = 3'd4
  } state_t;

  localparam int NLEGS = 12;

  localparam logic [11:0] SAFE_CMD_DEF = 12'hAAA;

  // Leg i drives gate[2i+1] (upper switch) and gate[2i] (lower switch).
  function automatic int gate_idx(input int leg, input logic upper);
    return leg + leg + (upper ? 32'sd1 : 32'sd0);
  endfunction

endpackage

// File: rtl/leg_deadtime.sv
// leg_deadtime: complementary gate pair for one converter leg with dead-time insertion.
//   clk, rst   : clock, asynchronous active-high reset
//   force_off  : hold both switches off and keep the dead-time counter loaded
//   cmd_bit    : requested side (1 = upper on, 0 = lower on)
//   up, lo     : registered upper/lower gate drives, never both high
//   busy       : dead-time counter is nonzero
// Any change of cmd_bit switches both sides off on the next edge and reloads the
// counter; the requested side is driven on the edge where the counter reaches 0,
// so the both-off gap is exactly DT_CYCLES clocks.
module leg_deadtime import disparo_pkg::*; #(
  parameter int unsigned DT_CYCLES = 50,
  parameter logic        RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic force_off,
  input  logic cmd_bit,
  output logic up,
  output logic lo,
  output logic busy
);

  localparam logic [9:0] DT_LOAD = 10'(DT_CYCLES);

  logic [9:0] cnt_r;
  logic       prev_r;
  logic       up_r;
  logic       lo_r;
  logic       chg_s;

  assign chg_s = cmd_bit ^ prev_r;

  // Change detection, dead-time countdown and gate pair drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= 10'd0;
      prev_r <= RESET_BIT;
      up_r   <= RESET_BIT;
      lo_r   <= ~RESET_BIT;
    end else begin
      prev_r <= cmd_bit;
      if (force_off || chg_s) begin
        // Latest change wins: a change inside the gap restarts it.
        cnt_r <= DT_LOAD;
        up_r  <= 1'b0;
        lo_r  <= 1'b0;
      end else if (cnt_r != 10'd0) begin
        cnt_r <= cnt_r - 10'd1;
        if (cnt_r == 10'd1) begin
          up_r <= cmd_bit;
          lo_r <= ~cmd_bit;
        end else begin
          up_r <= 1'b0;
          lo_r <= 1'b0;
        end
      end else begin
        up_r <= cmd_bit;
        lo_r <= ~cmd_bit;
      end
    end
  end

  assign up   = up_r;
  assign lo   = lo_r;
  assign busy = (cnt_r != 10'd0);

endmodule

// File: rtl/disparo_sequencer.sv
// disparo_sequencer: start/stop/trip sequencer and 24-output dead-time gate stage
// between the firing-pattern generator and the MMC gate-driver pins.
//   clk, rst     : 50 MHz clock, asynchronous active-high reset
//   period_flag  : single-cycle switching-period boundary strobe
//   fo_cmd[11:0] : leg commands {phC,phB,phA}, each {sa2,sb2,sa1,sb1}
//   enable       : run request (level)
//   fault        : external/overcurrent fault (level), forces TRIP
//   clr_trip     : single-cycle trip acknowledge
//   gate_out[23:0]  : leg i -> [2i+1]=upper, [2i]=lower
//   state[2:0]      : encoded state (IDLE=0, ARM=1, RUN=2, STOP=3, TRIP=4)
//   running         : high only in RUN
//   cmd_active[11:0]: command word currently applied to the dead-time stage
//   chk_err         : sticky shoot-through checker flag (only with SHOOT_THROUGH_CHK_EN)
// Optional feature macro: SHOOT_THROUGH_CHK_EN adds the gate-pair overlap checker
// and the chk_err port; without it neither exists.
module disparo_sequencer import disparo_pkg::*; #(
  parameter int unsigned DT_CYCLES   = 50,
  parameter int unsigned ARM_PERIODS = 4,
  parameter logic [11:0] SAFE_CMD    = SAFE_CMD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        period_flag,
  input  logic [11:0] fo_cmd,
  input  logic        enable,
  input  logic        fault,
  input  logic        clr_trip,
  output logic [23:0] gate_out,
  output logic [2:0]  state,
  output logic        running,
  output logic [11:0] cmd_active
`ifdef SHOOT_THROUGH_CHK_EN
  ,
  output logic        chk_err
`endif
);

  localparam logic [3:0] ARM_LAST = 4'(ARM_PERIODS - 32'd1);

  state_t      state_r;
  logic [3:0]  arm_cnt_r;
  logic        stop_safe_r;
  logic        running_r;
  logic [11:0] cmd_active_r;
  logic [11:0] cmd_prev_r;
  logic [11:0] pending_s;
  logic [NLEGS-1:0] up_s;
  logic [NLEGS-1:0] lo_s;
  logic [NLEGS-1:0] busy_s;
  logic [23:0] gate_s;
  logic        trip_req_s;
  logic        force_off_s;

  // Legs whose new command bit has not yet reached their change detector.
  assign pending_s = cmd_active_r ^ cmd_prev_r;

`ifdef SHOOT_THROUGH_CHK_EN
  localparam logic DT_SHORT = (DT_CYCLES < 32'd2);

  logic ovl_s;
  logic guard_s;
  logic chk_viol_s;
  logic chk_err_r;

  // Overlap detector on the registered gate pairs.
  always_comb begin
    ovl_s = 1'b0;
    for (int i = 0; i < NLEGS; i++) begin
      ovl_s = ovl_s | (gate_s[gate_idx(i, 1'b1)] & gate_s[gate_idx(i, 1'b0)]);
    end
  end

  // A too-short dead time cannot absorb a command change landing mid-gap.
  assign guard_s    = DT_SHORT & (|(pending_s & busy_s));
  assign chk_viol_s = ovl_s | guard_s;
  assign trip_req_s = fault | chk_viol_s;

  // Sticky checker error, set on violation, cleared by trip acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err_r <= 1'b0;
    end else if (chk_viol_s) begin
      chk_err_r <= 1'b1;
    end else if (clr_trip) begin
      chk_err_r <= 1'b0;
    end
  end

  assign chk_err = chk_err_r;
`else
  assign trip_req_s = fault;
`endif

  // Gates go off in the same edge that enters TRIP, and stay loaded with a full
  // dead time through the exit edge so every leg restarts with a complete gap.
  assign force_off_s = trip_req_s | (state_r == ST_TRIP);

  // Sequencer FSM with arm counter and period-aligned command latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      arm_cnt_r    <= 4'd0;
      stop_safe_r  <= 1'b0;
      running_r    <= 1'b0;
      cmd_active_r <= SAFE_CMD;
    end else if (trip_req_s) begin
      state_r      <= ST_TRIP;
      arm_cnt_r    <= 4'd0;
      stop_safe_r  <= 1'b0;
      running_r    <= 1'b0;
      cmd_active_r <= SAFE_CMD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cmd_active_r <= SAFE_CMD;
          running_r    <= 1'b0;
          stop_safe_r  <= 1'b0;
          if (enable) begin
            state_r   <= ST_ARM;
            arm_cnt_r <= 4'd0;
          end
        end
        ST_ARM: begin
          if (!enable) begin
            state_r <= ST_IDLE;
          end else if (period_flag) begin
            if (arm_cnt_r == ARM_LAST) begin
              state_r      <= ST_RUN;
              running_r    <= 1'b1;
              cmd_active_r <= fo_cmd;
            end else begin
              arm_cnt_r <= arm_cnt_r + 4'd1;
            end
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_r   <= ST_STOP;
            running_r <= 1'b0;
            // A boundary coinciding with the stop request applies SAFE at once.
            if (period_flag) begin
              cmd_active_r <= SAFE_CMD;
              stop_safe_r  <= 1'b1;
            end
          end else if (period_flag) begin
            cmd_active_r <= fo_cmd;
          end
        end
        ST_STOP: begin
          if (!stop_safe_r) begin
            if (period_flag) begin
              cmd_active_r <= SAFE_CMD;
              stop_safe_r  <= 1'b1;
            end
          end else if (!(|busy_s) && !(|pending_s)) begin
            state_r     <= ST_IDLE;
            stop_safe_r <= 1'b0;
          end
        end
        ST_TRIP: begin
          cmd_active_r <= SAFE_CMD;
          if (clr_trip) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          running_r    <= 1'b0;
          cmd_active_r <= SAFE_CMD;
        end
      endcase
    end
  end

  // One-cycle delayed copy of the applied command for change tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_prev_r <= SAFE_CMD;
    end else begin
      cmd_prev_r <= cmd_active_r;
    end
  end

  for (genvar g = 0; g < NLEGS; g++) begin : g_leg
    leg_deadtime #(
      .DT_CYCLES (DT_CYCLES),
      .RESET_BIT (SAFE_CMD[g])
    ) u_leg (
      .clk       (clk),
      .rst       (rst),
      .force_off (force_off_s),
      .cmd_bit   (cmd_active_r[g]),
      .up        (up_s[g]),
      .lo        (lo_s[g]),
      .busy      (busy_s[g])
    );
    assign gate_s[gate_idx(g, 1'b1)] = up_s[g];
    assign gate_s[gate_idx(g, 1'b0)] = lo_s[g];
  end

  assign gate_out   = gate_s;
  assign state      = state_r;
  assign running    = running_r;
  assign cmd_active = cmd_active_r;

endmodule

// File: tb/tb_disparo_sequencer.sv
// tb_disparo_sequencer: directed self-checking bench for disparo_sequencer.
// Expected command latches go through a queue when a period_flag is driven and
// are compared after the edge; gate patterns come from a small expansion model.
module tb_disparo_sequencer;

  localparam int DT = 50;

  logic        clk;
  logic        rst;
  logic        period_flag;
  logic [11:0] fo_cmd;
  logic        enable;
  logic        fault;
  logic        clr_trip;
  logic [23:0] gate_out;
  logic [2:0]  state;
  logic        running;
  logic [11:0] cmd_active;
`ifdef SHOOT_THROUGH_CHK_EN
  logic        chk_err;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit mon_on    = 1'b0;
  logic [11:0] cmd_q[$];

  disparo_sequencer #(
    .DT_CYCLES   (50),
    .ARM_PERIODS (4),
    .SAFE_CMD    (12'hAAA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_flag (period_flag),
    .fo_cmd      (fo_cmd),
    .enable      (enable),
    .fault       (fault),
    .clr_trip    (clr_trip),
    .gate_out    (gate_out),
    .state       (state),
    .running     (running),
    .cmd_active  (cmd_active)
`ifdef SHOOT_THROUGH_CHK_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: bit=1 -> upper on, bit=0 -> lower on.
  function automatic logic [23:0] expand(input logic [11:0] c);
    logic [23:0] e;
    e = 24'h000000;
    for (int i = 0; i < 12; i++) begin
      e[i + i + 1] = c[i];
      e[i + i]     = ~c[i];
    end
    return e;
  endfunction

  function automatic logic [23:0] pairmask(input logic [11:0] m);
    logic [23:0] p;
    p = 24'h000000;
    for (int i = 0; i < 12; i++) begin
      p[i + i + 1] = m[i];
      p[i + i]     = m[i];
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flag_pulse(input logic [11:0] exp_cmd);
    period_flag = 1'b1;
    cmd_q.push_back(exp_cmd);
    tick();
    period_flag = 1'b0;
    check("cmd_latch", {20'h0, cmd_active}, {20'h0, cmd_q.pop_front()});
  endtask

  // Count edges until gate_out leaves pattern pat (bounded).
  task automatic wait_while(input logic [23:0] pat, output int n);
    n = 0;
    while (gate_out === pat && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic arm_to_run(input logic [11:0] cmd);
    enable = 1'b1;
    fo_cmd = cmd;
    tick();
    check("arm_entry", {29'h0, state}, 32'd1);
    for (int p = 1; p <= 4; p++) begin
      repeat (2) tick();
      flag_pulse(p == 4 ? cmd : 12'hAAA);
      check("arm_walk", {29'h0, state}, (p == 4) ? 32'd2 : 32'd1);
    end
  endtask

  // Upper and lower of any leg must never be on together.
  always @(negedge clk) begin
    if (mon_on) begin
      total_cnt++;
      assert ((gate_out & (gate_out >> 1) & 24'h555555) == 24'h000000) else begin
        bad_cnt++;
        $error("FAIL overlap: observed=%0h expected=no pair both high", gate_out);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int tot;
    logic [23:0] pat;

    rst = 1'b1; period_flag = 1'b0; fo_cmd = 12'h000;
    enable = 1'b0; fault = 1'b0; clr_trip = 1'b0;
    tick(); tick();
    check("rst_state", {29'h0, state}, 32'd0);
    check("rst_cmd", {20'h0, cmd_active}, 32'h0AAA);
    check("rst_gate", {8'h0, gate_out}, 32'h00999999);
    check("rst_running", {31'h0, running}, 32'd0);
`ifdef SHOOT_THROUGH_CHK_EN
    check("rst_chk_err", {31'h0, chk_err}, 32'd0);
`endif
    rst = 1'b0;
    mon_on = 1'b1;
    tick();
    check("idle_gate", {8'h0, gate_out}, {8'h0, expand(12'hAAA)});

    // Start-up: ARM for 4 periods, latch 0x555 on the 4th flag.
    arm_to_run(12'h555);
    check("run_running", {31'h0, running}, 32'd1);
    check("pre_gap_gate", {8'h0, gate_out}, {8'h0, expand(12'hAAA)});
    tick();
    check("gap_start", {8'h0, gate_out}, 32'h0);
    wait_while(24'h000000, n);
    check("gap_len_start", n, DT);
    check("run_gate_555", {8'h0, gate_out}, {8'h0, expand(12'h555)});

    // Mid-period fo_cmd change is ignored until the next boundary.
    fo_cmd = 12'h0F0;
    repeat (5) tick();
    check("hold_cmd", {20'h0, cmd_active}, 32'h0555);
    check("hold_gate", {8'h0, gate_out}, {8'h0, expand(12'h555)});
    flag_pulse(12'h0F0);
    check("gate_before_chg", {8'h0, gate_out}, {8'h0, expand(12'h555)});
    tick();
    pat = expand(12'h0F0) & ~pairmask(12'h555 ^ 12'h0F0);
    check("partial_gap", {8'h0, gate_out}, {8'h0, pat});
    wait_while(pat, n);
    check("gap_len_partial", n, DT);
    check("run_gate_0f0", {8'h0, gate_out}, {8'h0, expand(12'h0F0)});

    // Fault in the middle of a dead-time gap.
    fo_cmd = 12'h555;
    flag_pulse(12'h555);
    repeat (11) tick();
    fault = 1'b1;
    tick();
    check("trip_gate", {8'h0, gate_out}, 32'h0);
    check("trip_state", {29'h0, state}, 32'd4);
    check("trip_running", {31'h0, running}, 32'd0);
    clr_trip = 1'b1;
    tick();
    clr_trip = 1'b0;
    check("trip_hold_fault", {29'h0, state}, 32'd4);
    enable = 1'b0;
    fault = 1'b0;
    tick();
    check("trip_hold_noclr", {29'h0, state}, 32'd4);
    clr_trip = 1'b1;
    tick();
    clr_trip = 1'b0;
    check("trip_exit_state", {29'h0, state}, 32'd0);
    check("trip_exit_cmd", {20'h0, cmd_active}, 32'h0AAA);
    check("trip_exit_gate", {8'h0, gate_out}, 32'h0);
    wait_while(24'h000000, n);
    check("gap_len_trip", n, DT);
    check("trip_safe_gate", {8'h0, gate_out}, {8'h0, expand(12'hAAA)});

    // ARM abort, then normal stop through STOP.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    check("arm_abort", {29'h0, state}, 32'd0);
    arm_to_run(12'h555);
    tick();
    wait_while(24'h000000, n);
    check("gap_len_rerun", n, DT);
    enable = 1'b0;
    tick();
    check("stop_state", {29'h0, state}, 32'd3);
    check("stop_running", {31'h0, running}, 32'd0);
    check("stop_cmd_hold", {20'h0, cmd_active}, 32'h0555);
    enable = 1'b1;
    repeat (3) tick();
    check("stop_no_abort", {29'h0, state}, 32'd3);
    enable = 1'b0;
    flag_pulse(12'hAAA);
    tick();
    check("stop_gap_start", {8'h0, gate_out}, 32'h0);
    wait_while(24'h000000, n);
    check("gap_len_stop", n, DT);
    check("stop_wait_state", {29'h0, state}, 32'd3);
    check("stop_safe_gate", {8'h0, gate_out}, {8'h0, expand(12'hAAA)});
    tick();
    check("stop_to_idle", {29'h0, state}, 32'd0);

    // Double toggle of leg 0, 20 clocks apart: 70-clock gap.
    arm_to_run(12'h555);
    tick();
    wait_while(24'h000000, n);
    fo_cmd = 12'h554;
    flag_pulse(12'h554);
    tick();
    pat = expand(12'h555) & ~pairmask(12'h001);
    check("toggle_gap_start", {8'h0, gate_out}, {8'h0, pat});
    repeat (18) tick();
    fo_cmd = 12'h555;
    flag_pulse(12'h555);
    check("toggle_mid_gap", {8'h0, gate_out}, {8'h0, pat});
    wait_while(pat, n);
    tot = 19 + n;
    check("gap_len_toggle", tot, 70);
    check("toggle_final", {8'h0, gate_out}, {8'h0, expand(12'h555)});

    // enable drop together with a boundary: SAFE applied directly.
    fo_cmd = 12'h0F0;
    enable = 1'b0;
    flag_pulse(12'hAAA);
    check("stop_flag_state", {29'h0, state}, 32'd3);
    tick();
    wait_while(24'h000000, n);
    check("gap_len_stopflag", n, DT);
    tick();
    check("stopflag_idle", {29'h0, state}, 32'd0);

`ifdef SHOOT_THROUGH_CHK_EN
    // Backdoor overlap on leg 0 must trip and set chk_err.
    mon_on = 1'b0;
    force dut.gate_s = 24'h000003;
    tick();
    release dut.gate_s;
    #1;
    check("chk_trip_state", {29'h0, state}, 32'd4);
    check("chk_err_set", {31'h0, chk_err}, 32'd1);
    check("chk_trip_gate", {8'h0, gate_out}, 32'h0);
    mon_on = 1'b1;
    clr_trip = 1'b1;
    tick();
    clr_trip = 1'b0;
    check("chk_exit_state", {29'h0, state}, 32'd0);
    check("chk_err_clr", {31'h0, chk_err}, 32'd0);
`endif

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
